// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampling, runtime divider, receive FIFO and sticky error flags.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIV_W-1:0]                clk_div,
  input  logic                            rx_i,
  input  logic                            clear_err,
`ifdef UART_RX_PARITY_EN
  input  logic                            parity_odd,
  output logic                            parity_err,
`endif
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            frame_err,
  output logic                            overrun,
  output logic                            rx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  logic                 sync1_r, sync2_r, rx_s;
  logic [2:0]           state_r, state_nxt_s;
  logic [DIV_W-1:0]     timer_r, timer_nxt_s, div_r, div_nxt_s, div_clamp_s;
  logic [IDX_W-1:0]     bit_idx_r, idx_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                 timer_zero_s, push_req_s, frame_set_s;
  logic                 rx_busy_r;

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r, count_nxt_s;
  logic [DATA_BITS-1:0] rx_data_r, head_nxt_s;
  logic                 rx_valid_r, frame_err_r, overrun_r;
  logic                 pop_s, full_s, wr_en_s, ovr_set_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_set_s, parity_err_r;
`endif

  assign rx_s         = sync2_r;
  assign timer_zero_s = (timer_r == {DIV_W{1'b0}});
  assign div_clamp_s  = (clk_div < DIV_W'(4)) ? DIV_W'(4) : clk_div;

  // Receive FSM next-state and datapath; timer loaded with N-1 expires N cycles later
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    div_nxt_s   = div_r;
    idx_nxt_s   = bit_idx_r;
    shift_nxt_s = shift_r;
    push_req_s  = 1'b0;
    frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt_s = START;
          div_nxt_s   = div_clamp_s;
          timer_nxt_s = (div_clamp_s >> 1) - DIV_W'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (!timer_zero_s) begin
          timer_nxt_s = timer_r - DIV_W'(1);
        end else if (!rx_s) begin
          state_nxt_s = DATA;
          idx_nxt_s   = {IDX_W{1'b0}};
          timer_nxt_s = div_r - DIV_W'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        if (!timer_zero_s) begin
          timer_nxt_s = timer_r - DIV_W'(1);
        end else begin
          shift_nxt_s = {rx_s, shift_r[DATA_BITS-1:1]};
          timer_nxt_s = div_r - DIV_W'(1);
          if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
          end else begin
            idx_nxt_s = bit_idx_r + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!timer_zero_s) begin
          timer_nxt_s = timer_r - DIV_W'(1);
        end else begin
          par_set_s   = ((calc_parity(shift_r) ^ rx_s) != parity_odd);
          state_nxt_s = STOP;
          timer_nxt_s = div_r - DIV_W'(1);
        end
      end
`endif
      STOP: begin
        if (!timer_zero_s) begin
          timer_nxt_s = timer_r - DIV_W'(1);
        end else if (rx_s) begin
          push_req_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          frame_set_s = 1'b1;
          state_nxt_s = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Synchronizer and FSM registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      state_r   <= IDLE;
      timer_r   <= {DIV_W{1'b0}};
      div_r     <= {DIV_W{1'b0}};
      bit_idx_r <= {IDX_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      rx_busy_r <= 1'b0;
    end else begin
      sync1_r   <= rx_i;
      sync2_r   <= sync1_r;
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      div_r     <= div_nxt_s;
      bit_idx_r <= idx_nxt_s;
      shift_r   <= shift_nxt_s;
      rx_busy_r <= (state_nxt_s != IDLE);
    end
  end

  assign pop_s     = rx_valid_r && rx_ready;
  assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
  assign wr_en_s   = push_req_s && (!full_s || pop_s);
  assign ovr_set_s = push_req_s && full_s && !pop_s;

  // FIFO occupancy and registered head-of-queue selection
  always_comb begin
    count_nxt_s = count_r;
    head_nxt_s  = rx_data_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      if (count_r > CNT_W'(1)) begin
        head_nxt_s = mem_r[rd_ptr_r + PTR_W'(1)];
      end else if (wr_en_s) begin
        head_nxt_s = shift_r;
      end else begin
        head_nxt_s = rx_data_r;
      end
    end else if ((count_r == {CNT_W{1'b0}}) && wr_en_s) begin
      head_nxt_s = shift_r;
    end else begin
      head_nxt_s = rx_data_r;
    end
  end

  // FIFO storage, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_BITS{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rx_data_r  <= {DATA_BITS{1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_nxt_s;
      rx_data_r  <= head_nxt_s;
      rx_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      if (frame_set_s)    frame_err_r <= 1'b1;
      else if (clear_err) frame_err_r <= 1'b0;
      if (ovr_set_s)      overrun_r   <= 1'b1;
      else if (clear_err) overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (par_set_s)      parity_err_r <= 1'b1;
      else if (clear_err) parity_err_r <= 1'b0;
`endif
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign fifo_count = count_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign rx_busy    = rx_busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the user-project UART, on the chip side of the serial link.
- Receives 8N1 frames (8 data bits, no parity, 1 stop bit) on the mprj_io[5] receive line. The testbench UART drives this line.
- Recovers each byte by mid-bit sampling, using a runtime clock-per-bit divider.
- Buffers received bytes in a small FIFO and presents them to the Wishbone-side register logic through a valid/ready handshake. Framing and overrun errors are reported as sticky flags.

Parameters:
- DATA_BITS, 8, data bits per frame; bits arrive LSB first.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2 and at least 2.
- DIV_W, 16, width of the clk_div input.

Ports:
- clk  in  1  system clock (the Wishbone clock).
- rst_n  in  1  reset, synchronous, active-low.
- clk_div  in  DIV_W  clocks per bit; values below 4 are treated as 4.
- rx_i  in  1  serial receive line; idles high.
- clear_err  in  1  one-cycle pulse that clears frame_err and overrun.
- rx_data  out  DATA_BITS  byte at the FIFO head.
- rx_valid  out  1  FIFO is not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes currently held.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a completed byte was dropped because the FIFO was full.
- rx_busy  out  1  a frame is currently being received (FSM is not IDLE).

Behaviour:
- Reset (rst_n low at a clk edge) clears every output and internal state:
  - rx_data=0, rx_valid=0, fifo_count=0, frame_err=0, overrun=0, rx_busy=0.
  - FSM goes to IDLE.
  - Synchronizer flops are set to 1.
  - Reset mid-frame discards the partial byte.
- Input conditioning:
  - rx_i passes through a 2-FF synchronizer; all logic uses the synchronized value rx_s.
  - Each rx_s transition takes 2 cycles to reach the logic.
- Bit timer: a DIV_W-bit down-counter. The effective divider is D = max(clk_div, 4). clk_div is latched when a frame starts, so changing it mid-frame has no effect until the next frame.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s==0 → go to START and load the timer with D/2 (floor).
  - START: when the timer expires, sample rx_s.
    - 0 → go to DATA, bit index 0, load the timer with D.
    - 1 → false start; go to IDLE with no flags set.
  - DATA: when the timer expires, shift rx_s into bit[index] (LSB first).
    - After bit DATA_BITS-1 → go to STOP, load D.
  - STOP: when the timer expires, sample rx_s.
    - 1 → push the byte; go to IDLE.
    - 0 → set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This covers a break, i.e. the line held low.
- Timing: the stop-bit sample falls at about 9.5·D cycles after the falling edge of the start bit, plus 2 synchronizer cycles. The FSM returns to IDLE mid-stop-bit, so back-to-back frames with a single stop bit are received correctly.
- FIFO:
  - Push at the stop-sample cycle. The byte is visible on rx_data/rx_valid on the next cycle.
  - Pop when rx_valid && rx_ready. rx_data then shows the next entry on the following cycle.
  - Full and pushing, with no pop in the same cycle: the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - Full, with push and pop in the same cycle: both happen; fifo_count stays FIFO_DEPTH and no overrun.
  - Empty: rx_ready is ignored; rx_data holds its last value; fifo_count does not underflow.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - clear_err clears frame_err and overrun on the next cycle.
  - If clear_err coincides with a new error event, the set wins.
  - Flags never affect FIFO contents.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, sampled after D cycles.
  - A 1-bit input parity_odd is added: 0 selects even parity, 1 selects odd.
  - A sticky output parity_err is added; it is reset to 0 and cleared by clear_err.
  - On a parity mismatch, parity_err is set and the byte is still pushed if the stop bit is valid.
  - The stop-bit sample moves to about 10.5·D cycles after the start edge.
- When undefined: no parity_odd or parity_err ports; the frame is 8N1 exactly as described above.

Test Plan:
- clk_div=16, send 0x3D (61) as 8N1 → one push; rx_data=0x3D, rx_valid=1, fifo_count=1, flags 0; rx_ready pulse → rx_valid=0, fifo_count=0.
- clk_div=16, send 0x0F, 0xA5, 0x5A, 0xFF back-to-back, rx_ready held 0 → fifo_count=4; pops return them in order; no overrun.
- clk_div=16, rx_ready held 0, send 5 bytes (0x01–0x05) → overrun=1, FIFO holds 0x01–0x04; clear_err → overrun=0.
- clk_div=16, send frame 0x55 with stop bit low, then line low for 40 cycles → frame_err=1, no push, rx_busy=1 until the line rises, then the next frame 0x3D is received correctly.
- Low glitch of 5 cycles at clk_div=16 → false start; no push, no flags, FSM back in IDLE.
- clk_div=2 (clamped to 4) with 4-cycle bits carrying 0xC3; then reset asserted mid-frame → first byte received; after reset all outputs are 0 and the partial frame is not pushed.
